ctrl_ajuste_rtc: RTL and testbench
==================================

CTRL_AJUSTE_RTC -- requirements
Module: ctrl_ajuste_rtc

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning the cycles a held up/down button waits before auto-repeat starts.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning the cycles between auto-repeat pulses.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000_000, meaning the inactivity cycles before edit mode exits automatically.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port btn_edit  input  1  debounced level that toggles edit mode.
REQ-007 The block SHALL have port btn_next  input  1  debounced level that selects the next field.
REQ-008 The block SHALL have port btn_prev  input  1  debounced level that selects the previous field.
REQ-009 The block SHALL have port btn_up  input  1  debounced level that increments the selected field.
REQ-010 The block SHALL have port btn_down  input  1  debounced level that decrements the selected field.
REQ-011 The block SHALL have port en_count  output  4  selected field code: 0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year.
REQ-012 The block SHALL have port enUP  output  1  single-cycle increment strobe to the field counters.
REQ-013 The block SHALL have port enDOWN  output  1  single-cycle decrement strobe to the field counters.
REQ-014 The block SHALL have port editing  output  1  high while edit mode is active.

Function
REQ-015 Every button SHALL be edge-detected with one registered copy, and each rising edge SHALL act in the cycle after the input rises.
REQ-016 The main FSM SHALL have states IDLE and EDIT; an edit edge SHALL move IDLE->EDIT with en_count=1, and EDIT->IDLE with en_count=0.
REQ-017 In EDIT, a next edge SHALL advance en_count 1->2->...->6->1, and a prev edge SHALL step it 6->5->...->1->6.
REQ-018 If next and prev edges occur in the same cycle, en_count SHALL be unchanged.
REQ-019 In IDLE, next, prev, up and down SHALL be ignored, and en_count, enUP and enDOWN SHALL be 0.
REQ-020 The repeat FSM SHALL have states R_IDLE, R_HOLD and R_RPT, and SHALL track exactly one of btn_up or btn_down while the other is low.
REQ-021 In EDIT and R_IDLE, a rising edge of btn_up alone SHALL pulse enUP for exactly 1 cycle and enter R_HOLD; btn_down SHALL behave the same with enDOWN.
REQ-022 In R_HOLD, the pressed button held for HOLD_CYCLES cycles after the first pulse SHALL emit a pulse and enter R_RPT.
REQ-023 In R_RPT, one pulse SHALL be emitted every REPEAT_CYCLES cycles while the button is held.
REQ-024 Release of the tracked button, or the other direction button going high, SHALL return the repeat FSM to R_IDLE with no further pulses.
REQ-025 If btn_up and btn_down are both high, no pulse SHALL be emitted.
REQ-026 enUP and enDOWN SHALL never be high in the same cycle, and neither SHALL be high in the cycle en_count changes.
REQ-027 Any next, prev, up, down or edit edge, or any held up/down button, SHALL reload the inactivity counter.
REQ-028 After TIMEOUT_CYCLES cycles without activity in EDIT, the FSM SHALL go to IDLE and the repeat FSM to R_IDLE.
REQ-029 Exiting EDIT for any reason SHALL force the repeat FSM to R_IDLE in the same cycle.
REQ-030 Counter widths SHALL be $clog2 of the largest parameter, and counters SHALL saturate rather than wrap.

Reset
REQ-031 While reset is high, state SHALL be IDLE and R_IDLE, all counters and edge registers 0, and en_count=0, enUP=0, enDOWN=0, editing=0.
REQ-032 Reset asserted mid-edit or mid-repeat SHALL abort immediately with no pulse on the release edge.
REQ-033 Buttons already high when reset releases SHALL NOT be treated as edges.

Structure
REQ-034 The field codes FLD_NONE..FLD_YEAR, FLD_MAX=6 and the state encodings SHALL live in the shared package ajuste_pkg.
REQ-035 Hold/repeat timing SHALL be one sub-module, auto_repeat, instantiated once for the up/down pair.

Verification (HOLD=4, REPEAT=2, TIMEOUT=20)
REQ-036 Bench SHALL cover: edit edge, then next x2 -> en_count 1,2,3 and editing=1; prev at 1 -> en_count=6.
REQ-037 Bench SHALL cover: en_count=3, btn_up held 12 cycles -> enUP pulses at relative cycles 1, 5, 7, 9, 11 and none after release.
REQ-038 Bench SHALL cover: btn_up and btn_down rising together -> no pulses; next and prev together -> en_count unchanged.
REQ-039 Bench SHALL cover: EDIT idle for 20 cycles -> editing=0 and en_count=0; up edges afterward -> no enUP.
REQ-040 Bench SHALL cover: reset asserted during R_RPT with btn_down held, then released -> all outputs 0 and no enDOWN until the next btn_down rising edge in EDIT.
REQ-041 Bench SHALL cover: btn_edit held high through reset release -> remains IDLE until btn_edit falls and rises again.

Source files
------------

// File: rtl/ajuste_pkg.sv
// ajuste_pkg: field codes, FSM encodings and counter sizing shared by the RTC adjust controller
package ajuste_pkg;
  typedef enum logic [3:0] {
    FLD_NONE  = 4'd0,
    FLD_SEC   = 4'd1,
    FLD_MIN   = 4'd2,
    FLD_HOUR  = 4'd3,
    FLD_DAY   = 4'd4,
    FLD_MONTH = 4'd5,
    FLD_YEAR  = 4'd6
  } fld_t;
  localparam logic [3:0] FLD_MAX = 4'd6;
  typedef enum logic {IDLE, EDIT} main_st_t;
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_RPT} rpt_st_t;
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m < 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/auto_repeat.sv
// auto_repeat: hold/auto-repeat pulse generator for the up/down button pair
//   clk, reset            : clock, asynchronous active-high reset
//   clr                   : forces R_IDLE and suppresses any pulse this cycle
//   up, down              : button levels
//   up_edge, down_edge    : qualified rising edges of the same buttons
//   pulse_up, pulse_down  : registered single-cycle strobes
module auto_repeat import ajuste_pkg::*; #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CW            = cnt_width(HOLD_CYCLES, REPEAT_CYCLES, 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic up,
  input  logic down,
  input  logic up_edge,
  input  logic down_edge,
  output logic pulse_up,
  output logic pulse_down
);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(REPEAT_CYCLES - 1);
  rpt_st_t st, st_n;
  logic dir, dir_n, pu_n, pd_n, held, last;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= R_IDLE;
      dir <= 1'b0;
      cnt <= '0;
      pulse_up <= 1'b0;
      pulse_down <= 1'b0;
    end else begin
      st <= st_n;
      dir <= dir_n;
      cnt <= cnt_n;
      pulse_up <= pu_n;
      pulse_down <= pd_n;
    end
  // dir=0 tracks up, dir=1 tracks down; holding only counts while the other button stays low
  always_comb begin
    held = dir ? down & ~up : up & ~down;
    last = cnt == (st == R_HOLD ? H_LAST : R_LAST);
    st_n = st;
    dir_n = dir;
    cnt_n = '0;
    pu_n = 1'b0;
    pd_n = 1'b0;
    if (clr) st_n = R_IDLE;
    else if (st == R_IDLE) begin
      if (up_edge & ~down) begin
        st_n = R_HOLD;
        dir_n = 1'b0;
        pu_n = 1'b1;
      end else if (down_edge & ~up) begin
        st_n = R_HOLD;
        dir_n = 1'b1;
        pd_n = 1'b1;
      end
    end else if (!held) st_n = R_IDLE;
    else if (last) begin
      st_n = R_RPT;
      pu_n = ~dir;
      pd_n = dir;
    end else cnt_n = &cnt ? cnt : cnt + 1'b1;
  end
endmodule

// File: rtl/ctrl_ajuste_rtc.sv
// ctrl_ajuste_rtc: button-driven field selection and up/down adjust strobes for an RTC
//   clk, reset                                 : clock, asynchronous active-high reset
//   btn_edit/next/prev/up/down                 : debounced button levels
//   en_count                                   : selected field (0 none, 1 sec .. 6 year)
//   enUP, enDOWN                               : single-cycle adjust strobes
//   editing                                    : edit mode active
module ctrl_ajuste_rtc import ajuste_pkg::*; #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int REPEAT_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       editing
);
  localparam int CW = cnt_width(HOLD_CYCLES, REPEAT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  main_st_t st, st_n;
  logic [4:0] btn, btn_q, edge_d;
  logic [3:0] fld, fld_n;
  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic armed, act, tmo, leave, fld_chg, clr;
  assign btn = {btn_edit, btn_next, btn_prev, btn_up, btn_down};
  // armed stays low for the first cycle after reset so buttons already held then are not edges
  assign edge_d = armed ? btn & ~btn_q : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      btn_q <= '0;
      armed <= 1'b0;
      st <= IDLE;
      fld <= FLD_NONE;
      idle_cnt <= '0;
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
      st <= st_n;
      fld <= fld_n;
      idle_cnt <= idle_cnt_n;
    end
  always_comb begin
    act = |edge_d | btn_up | btn_down;
    tmo = st == EDIT && !act && idle_cnt == T_LAST;
    leave = st == EDIT && (edge_d[4] || tmo);
    fld_chg = st == EDIT && !leave && (edge_d[3] ^ edge_d[2]);
    clr = st != EDIT || leave || fld_chg;
    st_n = leave ? IDLE : (st == IDLE && edge_d[4]) ? EDIT : st;
    fld_n = leave ? FLD_NONE :
            st == IDLE ? (edge_d[4] ? FLD_SEC : FLD_NONE) :
            !fld_chg ? fld :
            edge_d[3] ? (fld == FLD_MAX ? FLD_SEC : fld + 4'd1) :
            (fld == FLD_SEC ? FLD_MAX : fld - 4'd1);
    idle_cnt_n = (st != EDIT || act) ? '0 : &idle_cnt ? idle_cnt : idle_cnt + 1'b1;
  end
  // clr also covers field changes so no strobe lands in the cycle en_count moves
  auto_repeat #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CW(CW)
  ) u_rpt (
    .clk(clk),
    .reset(reset),
    .clr(clr),
    .up(btn_up),
    .down(btn_down),
    .up_edge(edge_d[1]),
    .down_edge(edge_d[0]),
    .pulse_up(enUP),
    .pulse_down(enDOWN)
  );
  assign en_count = fld;
  assign editing = st == EDIT;
endmodule

// File: tb/tb_ctrl_ajuste_rtc.sv
// tb_ctrl_ajuste_rtc: directed and randomized checks of ctrl_ajuste_rtc against a behavioural model
module tb_ctrl_ajuste_rtc;
  localparam int H = 4, R = 2, T = 20;
  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] btn = '0;
  logic [3:0] en_count;
  logic enUP, enDOWN, editing;
  int n_chk = 0, n_pass = 0;
  int m_fld, m_idle, m_hdir, m_k;
  bit m_edit, m_armed, m_up, m_dn;
  logic [4:0] m_prev;

  ctrl_ajuste_rtc #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .btn_edit(btn[4]), .btn_next(btn[3]), .btn_prev(btn[2]), .btn_up(btn[1]), .btn_down(btn[0]),
    .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN), .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_fld = 0; m_idle = 0; m_hdir = 0; m_k = 0;
    m_edit = 0; m_armed = 0; m_up = 0; m_dn = 0; m_prev = '0;
  endtask

  // one clock of the model: m_k counts clocks since the press; pulses at k=0, k=H, then every R
  task automatic m_step();
    logic [4:0] e;
    bit act, was, ex, fc, held;
    e = m_armed ? (btn & ~m_prev) : 5'b0;
    act = (e != 0) || btn[1] || btn[0];
    was = m_edit; ex = 0; fc = 0;
    m_up = 0; m_dn = 0;
    if (!was) begin
      if (e[4]) begin m_edit = 1; m_fld = 1; end
      m_idle = 0;
    end else begin
      m_idle = act ? 0 : m_idle + 1;
      if (e[4] || m_idle == T) begin ex = 1; m_edit = 0; m_fld = 0; m_idle = 0; end
      else if (e[3] != e[2]) begin fc = 1; m_fld = e[3] ? (m_fld % 6) + 1 : (m_fld + 4) % 6 + 1; end
    end
    if (!was || ex || fc) m_hdir = 0;
    else if (m_hdir != 0) begin
      held = m_hdir == 1 ? (btn[1] && !btn[0]) : (btn[0] && !btn[1]);
      if (!held) m_hdir = 0;
      else begin
        m_k++;
        if (m_k == H || (m_k > H && (m_k - H) % R == 0)) begin
          if (m_hdir == 1) m_up = 1; else m_dn = 1;
        end
      end
    end else if (e[1] && !btn[0]) begin m_up = 1; m_hdir = 1; m_k = 0; end
    else if (e[0] && !btn[1]) begin m_dn = 1; m_hdir = 2; m_k = 0; end
    m_armed = 1;
    m_prev = btn;
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      m_step();
      @(posedge clk);
      #1;
      chk("en_count", en_count, m_fld);
      chk("enUP", enUP, m_up);
      chk("enDOWN", enDOWN, m_dn);
      chk("editing", editing, m_edit);
      chk("up_down_excl", enUP & enDOWN, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_en_count", en_count, 0);
    chk("rst_enUP", enUP, 0);
    chk("rst_enDOWN", enDOWN, 0);
    chk("rst_editing", editing, 0);
    @(posedge clk);
    #1;
    reset = 0;
    m_reset();
  endtask

  task automatic press(int b);
    btn[b] = 1; cyc(1);
    btn[b] = 0; cyc(1);
  endtask

  initial begin
    logic [4:0] mask;
    #2;
    do_reset();
    cyc(2);
    // enter edit, step fields forward and wrap backward
    btn[4] = 1; cyc(1);
    chk("edit_en_count", en_count, 1);
    chk("edit_editing", editing, 1);
    btn[4] = 0; cyc(1);
    press(3); chk("next1", en_count, 3 - 1);
    press(3); chk("next2", en_count, 3);
    press(2); press(2); chk("prev_to_sec", en_count, 1);
    press(2); chk("prev_wrap", en_count, 6);
    press(3); press(3); press(3); chk("back_to_hour", en_count, 3);
    // hold up: pulses at relative cycles 1,5,7,9,11, released at 12
    btn[1] = 1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 13) btn[1] = 0;
      cyc(1);
      chk("rpt_up", enUP, (i == 1 || i == 5 || i == 7 || i == 9 || i == 11) ? 1 : 0);
    end
    // both directions together, then next+prev together
    btn[1] = 1; btn[0] = 1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("both_up", enUP, 0);
      chk("both_down", enDOWN, 0);
    end
    btn[1] = 0; btn[0] = 0; cyc(1);
    btn[3] = 1; btn[2] = 1; cyc(1);
    chk("next_prev_same", en_count, 3);
    btn[3] = 0; btn[2] = 0; cyc(1);
    // inactivity timeout
    cyc(T);
    chk("tmo_editing", editing, 0);
    chk("tmo_en_count", en_count, 0);
    btn[1] = 1; cyc(1);
    chk("idle_up", enUP, 0);
    btn[1] = 0; cyc(1);
    press(1);
    // reset in the middle of a repeat with down held
    press(4);
    btn[0] = 1; cyc(8);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("post_rst_down", enDOWN, 0);
      chk("post_rst_editing", editing, 0);
    end
    btn[0] = 0; cyc(1);
    press(4);
    btn[0] = 1; cyc(1);
    chk("down_after_rst", enDOWN, 1);
    btn[0] = 0; cyc(1);
    // edit held across reset release
    btn[4] = 1;
    do_reset();
    cyc(4);
    chk("edit_held_rst", editing, 0);
    btn[4] = 0; cyc(1);
    btn[4] = 1; cyc(1);
    chk("edit_reedge", editing, 1);
    btn[4] = 0; cyc(1);
    // randomized button activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      mask[4] = $urandom_range(0, 29) == 0;
      mask[3] = $urandom_range(0, 9) == 0;
      mask[2] = $urandom_range(0, 9) == 0;
      mask[1] = $urandom_range(0, 7) == 0;
      mask[0] = $urandom_range(0, 7) == 0;
      btn = btn ^ mask;
      cyc(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
